// File: rtl/shuju_zhongcaiqi_pkg.sv
// Shared types and constants for the four-source round-robin selector arbiter.
package shuju_zhongcaiqi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  localparam int HOLD_DEFAULT = 4;
  localparam int CW_DEFAULT   = 4;

  // Returns {found, index} of the first set request scanning last+1, last+2, ... wrapping
  // back to last itself, so a lone current owner is found again after expiry.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/shuju_zhongcaiqi_shujuxuanzeqi.sv
// 2-bit 4:1 data selector with active-high disable forcing the output to zero.
module shujuxuanzeqi (
  input  logic [1:0] d0_i,
  input  logic [1:0] d1_i,
  input  logic [1:0] d2_i,
  input  logic [1:0] d3_i,
  input  logic [1:0] sel_i,
  input  logic       dis_i,
  output logic [1:0] y_o
);

  always_comb begin
    y_o = 2'b00;
    if (!dis_i) begin
      case (sel_i)
        2'd0:    y_o = d0_i;
        2'd1:    y_o = d1_i;
        2'd2:    y_o = d2_i;
        default: y_o = d3_i;
      endcase
    end
  end

endmodule

// File: rtl/shuju_zhongcaiqi.sv
// Round-robin arbiter sharing one 2-bit 4:1 selector among sources A..D, with each grant
// bounded to HOLD cycles and zero-cycle switchover between contending sources.
module shuju_zhongcaiqi
  import shuju_zhongcaiqi_pkg::*;
#(
  parameter int HOLD = HOLD_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic       EN,
  output logic [1:0] Y,
  output logic       VALID
);

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    last_q,  last_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic [1:0]    sel_q,   sel_d;
  logic          en_q,    en_d;

  logic [2:0]    pick;
  logic          rearb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_D;
      gnt_q   <= 4'b0000;
      sel_q   <= SRC_A;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    rearb   = 1'b0;
    pick    = rr_pick(REQ, last_q);

    case (state_q)
      IDLE: rearb = |REQ;
      BUSY: begin
        if (!REQ[sel_q] || cnt_q == HOLD_M1) rearb = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      default: rearb = 1'b1;
    endcase

    // Release and expiry share one rearbitration; S is left alone when going idle.
    if (rearb) begin
      cnt_d = '0;
      if (pick[2]) begin
        state_d = BUSY;
        sel_d   = pick[1:0];
        last_d  = pick[1:0];
        gnt_d   = 4'b0001 << pick[1:0];
        en_d    = 1'b0;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        en_d    = 1'b1;
      end
    end
  end

  assign GNT   = gnt_q;
  assign S     = sel_q;
  assign EN    = en_q;
  assign VALID = ~en_q;

  shujuxuanzeqi u_sel (
    .d0_i (A),
    .d1_i (B),
    .d2_i (C),
    .d3_i (D),
    .sel_i(sel_q),
    .dis_i(en_q),
    .y_o  (Y)
  );

endmodule

// File: tb/tb_shuju_zhongcaiqi.sv
// Bench for shuju_zhongcaiqi: HOLD=4 and HOLD=1 instances against a behavioural arbitration model.
module tb_shuju_zhongcaiqi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [1:0] A, B, C, D;
  logic [3:0] GNT, GNT1;
  logic [1:0] S, S1, Y, Y1;
  logic       EN, EN1, VALID, VALID1;

  int n_vec = 0;
  int n_err = 0;

  // model state per instance: 0 -> HOLD=4, 1 -> HOLD=1
  bit m_busy [2];
  int m_own  [2];
  int m_cnt  [2];
  int m_last [2];
  int hold_of [2] = '{4, 1};

  always #5 CLK = ~CLK;

  shuju_zhongcaiqi #(.HOLD(4), .CW(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT), .S(S), .EN(EN), .Y(Y), .VALID(VALID)
  );

  shuju_zhongcaiqi #(.HOLD(1), .CW(2)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT1), .S(S1), .EN(EN1), .Y(Y1), .VALID(VALID1)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_own[k]  = 0;
      m_cnt[k]  = 0;
      m_last[k] = 3;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    bit found;
    int nxt;
    found = 1'b0;
    nxt   = 0;
    if (m_busy[k] && r[m_own[k]] && m_cnt[k] < hold_of[k] - 1) begin
      m_cnt[k]++;
    end else begin
      for (int j = 1; j <= 4; j++)
        if (!found && r[(m_last[k] + j) % 4]) begin
          found = 1'b1;
          nxt   = (m_last[k] + j) % 4;
        end
      if (found) begin
        m_busy[k] = 1'b1;
        m_own[k]  = nxt;
        m_last[k] = nxt;
        m_cnt[k]  = 0;
      end else if (m_busy[k] || r != 4'b0000) begin
        m_busy[k] = 1'b0;
      end
    end
  endtask

  // {GNT, S, EN, VALID, Y}
  function automatic logic [9:0] exp_vec(input int k);
    logic [1:0] d [4];
    logic [3:0] g;
    logic [1:0] y;
    d[0] = A; d[1] = B; d[2] = C; d[3] = D;
    g = m_busy[k] ? (4'b0001 << m_own[k]) : 4'b0000;
    y = m_busy[k] ? d[m_own[k]] : 2'b00;
    return {g, 2'(m_own[k]), ~m_busy[k], m_busy[k], y};
  endfunction

  task automatic tick(input logic [3:0] r);
    REQ = r;
    @(posedge CLK);
    model_step(0, r);
    model_step(1, r);
    #1;
  endtask

  task automatic do_reset();
    REQ = 4'b0000;
    RST = 1'b1;
    model_reset();
    #3;
    RST = 1'b0;
  endtask

  task automatic rand_data();
    A = 2'($urandom); B = 2'($urandom); C = 2'($urandom); D = 2'($urandom);
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 4'b0000; A = 2'b01; B = 2'b10; C = 2'b11; D = 2'b01;
    model_reset();
    #12;
    n_vec++;
    if ({GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
      n_err++;
      $display("FAIL reset_state dut: got %b want %b", {GNT, S, EN, VALID, Y}, exp_vec(0));
    end
    n_vec++;
    if ({GNT1, S1, EN1, VALID1, Y1} !== exp_vec(1)) begin
      n_err++;
      $display("FAIL reset_state dut1: got %b want %b", {GNT1, S1, EN1, VALID1, Y1}, exp_vec(1));
    end
    #1 RST = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    rand_data();
    for (int i = 0; i < 2; i++) begin
      tick(4'b0010);
      n_vec++;
      if ({GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL midgrant_b c%0d: got %b want %b", i, {GNT, S, EN, VALID, Y}, exp_vec(0));
      end
    end
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({GNT, EN, Y} !== {4'b0000, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL async_reset: got GNT=%b EN=%b Y=%b want 0000/1/00", GNT, EN, Y);
    end
    RST = 1'b0;
    tick(4'b0011);
    n_vec++;
    if ({GNT, S, EN} !== {4'b0001, 2'd0, 1'b0} || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
      n_err++;
      $display("FAIL after_reset_a: got %b want %b", {GNT, S, EN, VALID, Y}, exp_vec(0));
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    A = 2'b01; B = 2'b11; C = 2'b10; D = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      tick(4'b0100);
      n_vec++;
      if ({GNT, S, EN, Y} !== {4'b0100, 2'd2, 1'b0, 2'b10} || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL single_c c%0d: got %b want %b", i, {GNT, S, EN, VALID, Y}, exp_vec(0));
      end
    end
  endtask

  task automatic test_full_contention();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_data();
      tick(4'b1111);
      want = 4'b0001 << ((i / 4) % 4);
      n_vec++;
      if (GNT !== want || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL contention c%0d: got %b want %b (gnt %b)", i, {GNT, S, EN, VALID, Y}, exp_vec(0), want);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    rand_data();
    tick(4'b1001);
    tick(4'b1001);
    n_vec++;
    if (GNT !== 4'b0001) begin
      n_err++;
      $display("FAIL early_a: got %b want 0001", GNT);
    end
    tick(4'b1000);
    n_vec++;
    if ({GNT, S} !== {4'b1000, 2'd3} || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
      n_err++;
      $display("FAIL early_switch_d: got %b want %b", {GNT, S, EN, VALID, Y}, exp_vec(0));
    end
    // D keeps three more cycles (fresh count), then A gets its turn
    for (int i = 0; i < 5; i++) begin
      tick(4'b1001);
      n_vec++;
      if (GNT !== (i < 3 ? 4'b1000 : 4'b0001) || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL early_cnt c%0d: got %b want %b", i, {GNT, S, EN, VALID, Y}, exp_vec(0));
      end
    end
  endtask

  task automatic test_all_drop();
    do_reset();
    rand_data();
    for (int i = 0; i < 3; i++) tick(4'b1000);
    tick(4'b0000);
    n_vec++;
    if ({GNT, S, EN, VALID, Y} !== {4'b0000, 2'd3, 1'b1, 1'b0, 2'b00}) begin
      n_err++;
      $display("FAIL drop_idle: got %b want 0000111000", {GNT, S, EN, VALID, Y});
    end
    tick(4'b1001);
    n_vec++;
    if ({GNT, S, EN} !== {4'b0001, 2'd0, 1'b0} || {GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
      n_err++;
      $display("FAIL drop_then_a: got %b want %b", {GNT, S, EN, VALID, Y}, exp_vec(0));
    end
  endtask

  task automatic test_hold1();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rand_data();
      tick(4'b0110);
      n_vec++;
      if (GNT1 !== (i % 2 == 0 ? 4'b0010 : 4'b0100) || {GNT1, S1, EN1, VALID1, Y1} !== exp_vec(1)) begin
        n_err++;
        $display("FAIL hold1 c%0d: got %b want %b", i, {GNT1, S1, EN1, VALID1, Y1}, exp_vec(1));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      rand_data();
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      tick(r);
      n_vec++;
      if ({GNT, S, EN, VALID, Y} !== exp_vec(0)) begin
        n_err++;
        $display("FAIL random4 c%0d req=%b: got %b want %b", i, r, {GNT, S, EN, VALID, Y}, exp_vec(0));
      end
      n_vec++;
      if ({GNT1, S1, EN1, VALID1, Y1} !== exp_vec(1)) begin
        n_err++;
        $display("FAIL random1 c%0d req=%b: got %b want %b", i, r, {GNT1, S1, EN1, VALID1, Y1}, exp_vec(1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_grant();
    test_single_requester();
    test_full_contention();
    test_early_release();
    test_all_drop();
    test_hold1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
